ram_dp_arb: RTL and testbench

Parametrised two-port on-chip RAM with byte-lane write strobes, registered read data, and a round-robin arbiter over a single storage array. Port A serves instruction fetch (read-only). Port B serves the load/store path (read/write). Both sit on the SoC peripheral bus. Out-of-range and misaligned accesses complete with an error flag instead of touching memory.

---
 rtl/ram_dp_arb.sv | 144 ++++++++++++++
 tb/tb_ram_dp_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_arb.sv
// ram_dp_arb: dual-port front end over a single-ported RAM array.
//   Port A (a_*): read-only port for instruction fetch.
//   Port B (b_*): read/write port for the load/store path, with byte-lane
//                 write strobes.
// A round-robin arbiter grants at most one access per cycle. When both ports
// request in the same cycle, the port named by prio_q wins and prio_q then
// passes to the losing port.
// Each accepted access gives exactly one rvalid pulse in the following cycle.
// A misaligned or out-of-range access returns err=1 and data=0, and it does
// not touch the array.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   a_req_i/a_addr_i    port A request and byte address
//   a_gnt_o             port A accepted this cycle (combinational)
//   a_rvalid_o/a_err_o/a_data_o   port A response
//   b_req_i/b_we_i/b_wstrb_i/b_addr_i/b_data_i   port B request
//   b_gnt_o             port B accepted this cycle (combinational)
//   b_rvalid_o/b_err_o/b_data_o   port B response
module ram_dp_arb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  output logic                a_gnt_o,
  output logic                a_rvalid_o,
  output logic                a_err_o,
  output logic [DATA_W-1:0]   a_data_o,
  input  logic                b_req_i,
  input  logic                b_we_i,
  input  logic [DATA_W/8-1:0] b_wstrb_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_data_i,
  output logic                b_gnt_o,
  output logic                b_rvalid_o,
  output logic                b_err_o,
  output logic [DATA_W-1:0]   b_data_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e prio_q, prio_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_bad, b_bad;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic              a_gnt, b_gnt;

  logic              a_rvalid_q, b_rvalid_q;
  logic              a_err_q, b_err_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;

  // An address is bad if it has offset bits within a word, or if it has any
  // bit set above the word-index field. The second test is the same as
  // index >= DEPTH because DEPTH is a power of two.
  always_comb begin
    a_bad = (|(a_addr_i & ALIGN_MASK)) | (|(a_addr_i >> (LSB + IDX_W)));
    b_bad = (|(b_addr_i & ALIGN_MASK)) | (|(b_addr_i >> (LSB + IDX_W)));
    a_idx = a_addr_i[LSB +: IDX_W];
    b_idx = b_addr_i[LSB +: IDX_W];
  end

  // The grant is combinational. It is forced low while rst is asserted, so
  // no access, and in particular no write, can happen during reset.
  always_comb begin
    a_gnt = rst & a_req_i & (~b_req_i | (prio_q == PRIO_A));
    b_gnt = rst & b_req_i & (~a_req_i | (prio_q == PRIO_B));
  end

  // prio_q changes only on a conflict. On a conflict the winner is prio_q,
  // so handing priority to the loser is the same as toggling prio_q.
  always_comb begin
    prio_d = prio_q;
    if (rst && a_req_i && b_req_i) begin
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  // The array has no reset. Writes are already blocked during reset because
  // b_gnt is held low while rst is asserted.
  always_ff @(posedge clk) begin
    if (b_gnt && b_we_i && !b_bad) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (b_wstrb_i[k]) begin
          mem[b_idx][8*k +: 8] <= b_data_i[8*k +: 8];
        end
      end
    end
  end

  // Response registers. data_q changes only on a read or an error, so a
  // write response leaves the last read data in place.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
    end else begin
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt;
      a_err_q    <= a_gnt & a_bad;
      b_err_q    <= b_gnt & b_bad;
      if (a_gnt) begin
        a_data_q <= a_bad ? '0 : mem[a_idx];
      end
      if (b_gnt && (b_bad || !b_we_i)) begin
        b_data_q <= b_bad ? '0 : mem[b_idx];
      end
    end
  end

  assign a_gnt_o    = a_gnt;
  assign b_gnt_o    = b_gnt;
  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_err_o    = a_err_q;
  assign b_err_o    = b_err_q;
  assign a_data_o   = a_data_q;
  assign b_data_o   = b_data_q;

endmodule

// File: tb/tb_ram_dp_arb.sv
// Testbench for ram_dp_arb. It uses two instances: the default 32-bit /
// 4096-word build (a_*/b_*) and a 64-bit / 256-word build on port B (c_*).
module tb_ram_dp_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        a_req, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_data;
  logic        b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr, b_wdata, b_rdata;

  // Wide instance
  logic        d_req, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr;
  logic [63:0] d_data;
  logic        c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [7:0]  c_wstrb;
  logic [31:0] c_addr;
  logic [63:0] c_wdata, c_rdata;

  int checks = 0;
  int errors = 0;

  ram_dp_arb u_dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_gnt_o(a_gnt),
    .a_rvalid_o(a_rvalid), .a_err_o(a_err), .a_data_o(a_data),
    .b_req_i(b_req), .b_we_i(b_we), .b_wstrb_i(b_wstrb), .b_addr_i(b_addr),
    .b_data_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
    .b_err_o(b_err), .b_data_o(b_rdata)
  );

  ram_dp_arb #(.DATA_W(64), .DEPTH(256), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst),
    .a_req_i(d_req), .a_addr_i(d_addr), .a_gnt_o(d_gnt),
    .a_rvalid_o(d_rvalid), .a_err_o(d_err), .a_data_o(d_data),
    .b_req_i(c_req), .b_we_i(c_we), .b_wstrb_i(c_wstrb), .b_addr_i(c_addr),
    .b_data_i(c_wdata), .b_gnt_o(c_gnt), .b_rvalid_o(c_rvalid),
    .b_err_o(c_err), .b_data_o(c_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One port-B access on the default instance. The request is held for one
  // cycle, and the response is checked in the cycle after that.
  task automatic bop(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                     input logic [31:0] wd, input logic exp_err, input logic dchk,
                     input logic [31:0] exp_d);
    @(negedge clk);
    b_req = 1'b1; b_we = we; b_wstrb = strb; b_addr = addr; b_wdata = wd;
    #1 chk("b_gnt", b_gnt, 1);
    @(negedge clk);
    b_req = 1'b0;
    chk("b_rvalid", b_rvalid, 1);
    chk("b_err", b_err, exp_err);
    if (dchk) chk("b_data", b_rdata, exp_d);
  endtask

  task automatic aop(input logic [31:0] addr, input logic exp_err, input logic [31:0] exp_d);
    @(negedge clk);
    a_req = 1'b1; a_addr = addr;
    #1 chk("a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    chk("a_rvalid", a_rvalid, 1);
    chk("a_err", a_err, exp_err);
    chk("a_data", a_data, exp_d);
  endtask

  task automatic cop(input logic we, input logic [7:0] strb, input logic [31:0] addr,
                     input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_d);
    @(negedge clk);
    c_req = 1'b1; c_we = we; c_wstrb = strb; c_addr = addr; c_wdata = wd;
    #1 chk("c_gnt", c_gnt, 1);
    @(negedge clk);
    c_req = 1'b0;
    chk("c_rvalid", c_rvalid, 1);
    chk("c_err", c_err, exp_err);
    if (!we) chk("c_data", c_rdata, exp_d);
  endtask

  initial begin
    logic pa, pb, ea, eb;
    a_req = 1'b1; a_addr = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_wstrb = 4'h0; b_addr = 32'h4; b_wdata = '0;
    d_req = 1'b0; d_addr = '0;
    c_req = 1'b1; c_we = 1'b0; c_wstrb = '0; c_addr = '0; c_wdata = '0;

    // Reset: both ports request, but nothing may be granted.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_data", a_data, 0);
      chk("rst_b_data", b_rdata, 0);
      chk("rst_c_data", c_rdata, 0);
    end
    c_req = 1'b0;

    // Release reset with both ports requesting: grants go A,B,A,B.
    pa = 1'b0; pb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      chk("arb_a_rvalid", a_rvalid, pa);
      chk("arb_b_rvalid", b_rvalid, pb);
      chk("arb_a_err", a_err, 0);
      chk("arb_b_err", b_err, 0);
      if (i == 4) begin a_req = 1'b0; b_req = 1'b0; end
      #1;
      ea = (i % 2 == 0) && (i < 4);
      eb = (i % 2 == 1) && (i < 4);
      chk("arb_a_gnt", a_gnt, ea);
      chk("arb_b_gnt", b_gnt, eb);
      pa = ea; pb = eb;
    end

    // Byte strobes
    bop(1'b1, 4'hF, 32'h10, 32'h11223344, 1'b0, 1'b0, 32'h0);
    bop(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h11223344);
    @(negedge clk);
    chk("b_rvalid_one_cycle", b_rvalid, 0);
    bop(1'b1, 4'b0101, 32'h10, 32'hAABBCCDD, 1'b0, 1'b1, 32'h11223344);
    bop(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h11BB33DD);
    bop(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h11BB33DD);
    bop(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h11BB33DD);

    // Errors. An out-of-range write must not alias onto word 4.
    bop(1'b0, 4'h0, 32'h4002, 32'h0, 1'b1, 1'b1, 32'h0);
    aop(32'h4000, 1'b1, 32'h0);
    bop(1'b1, 4'hF, 32'h4010, 32'h0, 1'b1, 1'b1, 32'h0);
    aop(32'h10, 1'b0, 32'h11BB33DD);
    bop(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h11BB33DD);

    // Read-after-write across ports.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_wstrb = 4'hF; b_addr = 32'h20; b_wdata = 32'hDEADBEEF;
    #1 chk("raw_b_gnt", b_gnt, 1);
    @(negedge clk);
    b_req = 1'b0; a_req = 1'b1; a_addr = 32'h20;
    chk("raw_b_rvalid", b_rvalid, 1);
    #1 chk("raw_a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    chk("raw_a_rvalid", a_rvalid, 1);
    chk("raw_a_data", a_data, 32'hDEADBEEF);
    chk("raw_b_rvalid_low", b_rvalid, 0);

    // A write attempted during reset must not reach the array.
    @(negedge clk);
    rst = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_wstrb = 4'hF; b_addr = 32'h10; b_wdata = 32'h0;
    #1 chk("rst_mid_b_gnt", b_gnt, 0);
    @(negedge clk);
    chk("rst_mid_b_data", b_rdata, 0);
    b_req = 1'b0; rst = 1'b1;
    bop(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h11BB33DD);

    // 64-bit / 256-word instance
    cop(1'b1, 8'hFF, 32'h7F8, 64'h0123456789ABCDEF, 1'b0, 64'h0);
    cop(1'b1, 8'hA5, 32'h7F8, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0);
    cop(1'b0, 8'h00, 32'h7F8, 64'h0, 1'b0, 64'hFF23FF6789FFCDFF);
    cop(1'b0, 8'h00, 32'h800, 64'h0, 1'b1, 64'h0);
    cop(1'b0, 8'h00, 32'h7FC, 64'h0, 1'b1, 64'h0);
    cop(1'b1, 8'hFF, 32'hFF8, 64'h0, 1'b1, 64'h0);
    cop(1'b0, 8'h00, 32'h7F8, 64'h0, 1'b0, 64'hFF23FF6789FFCDFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
